// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request kinds and
// the latched request record.
package dmem_pkg;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        REQ_READ,
        REQ_WRITE,
        REQ_BOTH
    } req_kind_e;

    typedef struct packed {
        req_kind_e          kind;
        logic [WORD_W-1:0]  addr;
        logic [WORD_W-1:0]  data;
        logic [3:0]         be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
interface dmem_responder_if #(
    parameter int address_size = 32
);
    logic                    MemRead;
    logic                    MemWrite;
    logic [address_size-1:0] daddr;
    logic [address_size-1:0] ddata_w;
    logic [3:0]              be;
    logic [address_size-1:0] ddata_r;
    logic                    ready;
    logic                    err;
    logic                    busy;

    modport master (
        output MemRead, MemWrite, daddr, ddata_w, be,
        input  ddata_r, ready, err, busy
    );

    modport slave (
        input  MemRead, MemWrite, daddr, ddata_w, be,
        output ddata_r, ready, err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module dmem_array #(
    parameter int data_size = 1024,
    parameter int IDX_W     = (data_size > 1) ? $clog2(data_size) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [data_size];

    // NOTE: no reset on the storage array; contents must survive reset and a
    // reset branch here would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request in IDLE, waits WAIT_CYCLES, then
// pulses ready. Define DMEM_MISALIGN_CHECK_EN to reject non-word-aligned addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int data_size    = 1024,
    parameter int address_size = 32,
    parameter int WAIT_CYCLES  = 1
) (
    input logic            CLK,
    input logic            RESET,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = (data_size > 1) ? $clog2(data_size) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    dmem_req_t        req;
    logic [31:0]      rdata_q;
    logic [31:0]      mem_rdata;
    logic             accept;
    logic             out_of_range;
    logic             misaligned;
    logic             req_err;
    logic             do_write;
    logic             do_read;

    assign accept = (state == IDLE) && (bus.MemRead || bus.MemWrite);

    // Errors are judged on the latched request so late input changes cannot matter.
    assign out_of_range = {2'b00, req.addr[31:2]} >= 32'(data_size);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = |req.addr[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req.addr[1:0];
    assign misaligned      = 1'b0;
`endif
    assign req_err = (req.kind == REQ_BOTH) || out_of_range || misaligned;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        do_write    = 1'b0;
        do_read     = 1'b0;
        bus.ready   = 1'b0;
        bus.err     = 1'b0;
        bus.busy    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_next = RESP;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            RESP: begin
                state_next = IDLE;
                // A reset landing on the response cycle abandons the request.
                bus.ready  = !RESET;
                bus.err    = !RESET && req_err;
                do_write   = !RESET && !req_err && (req.kind == REQ_WRITE);
                do_read    = !req_err && (req.kind == REQ_READ);
            end
            default: state_next = IDLE;
        endcase
        bus.ddata_r = address_size'(do_read ? mem_rdata : rdata_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                req.kind <= (bus.MemRead && bus.MemWrite) ? REQ_BOTH :
                            (bus.MemWrite ? REQ_WRITE : REQ_READ);
                req.addr <= 32'(bus.daddr);
                req.data <= 32'(bus.ddata_w);
                req.be   <= bus.be;
            end
            if (do_read) rdata_q <= mem_rdata;
        end
    end

    dmem_array #(
        .data_size (data_size),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (CLK),
        .we    (do_write),
        .be    (req.be),
        .addr  (req.addr[IDX_W+1:2]),
        .wdata (req.data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=1 and 0) checked every cycle
// against a transaction-timeline model, plus directed literal scenarios.
module tb_dmem_responder;

    localparam int DSIZE = 1024;
    localparam int W0    = 1;
    localparam int W1    = 0;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    dmem_responder_if #(.address_size(32)) bus0 ();
    dmem_responder_if #(.address_size(32)) bus1 ();

    dmem_responder #(.data_size(DSIZE), .address_size(32), .WAIT_CYCLES(W0)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0)
    );
    dmem_responder #(.data_size(DSIZE), .address_size(32), .WAIT_CYCLES(W1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1)
    );

    logic        drv_rd   [2];
    logic        drv_wr   [2];
    logic [31:0] drv_addr [2];
    logic [31:0] drv_data [2];
    logic [3:0]  drv_be   [2];

    assign bus0.MemRead  = drv_rd[0];
    assign bus0.MemWrite = drv_wr[0];
    assign bus0.daddr    = drv_addr[0];
    assign bus0.ddata_w  = drv_data[0];
    assign bus0.be       = drv_be[0];
    assign bus1.MemRead  = drv_rd[1];
    assign bus1.MemWrite = drv_wr[1];
    assign bus1.daddr    = drv_addr[1];
    assign bus1.ddata_w  = drv_data[1];
    assign bus1.be       = drv_be[1];

    logic        o_ready [2];
    logic        o_err   [2];
    logic        o_busy  [2];
    logic [31:0] o_dr    [2];

    assign o_ready[0] = bus0.ready;
    assign o_err[0]   = bus0.err;
    assign o_busy[0]  = bus0.busy;
    assign o_dr[0]    = bus0.ddata_r;
    assign o_ready[1] = bus1.ready;
    assign o_err[1]   = bus1.err;
    assign o_busy[1]  = bus1.busy;
    assign o_dr[1]    = bus1.ddata_r;

    // Inputs as seen by the DUT at each rising edge.
    logic        s_rst;
    logic        s_rd   [2];
    logic        s_wr   [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_data [2];
    logic [3:0]  s_be   [2];

    always @(posedge CLK) begin
        s_rst <= RESET;
        for (int d = 0; d < 2; d++) begin
            s_rd[d]   <= drv_rd[d];
            s_wr[d]   <= drv_wr[d];
            s_addr[d] <= drv_addr[d];
            s_data[d] <= drv_data[d];
            s_be[d]   <= drv_be[d];
        end
    end

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one pending request per DUT with the cycle its response is due.
    int          cyc = 0;
    bit          pend     [2];
    int          rdy_cyc  [2];
    bit          m_rd     [2];
    bit          m_wr     [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_data   [2];
    logic [3:0]  m_be     [2];
    logic [31:0] rd_val   [2];
    bit          rd_known [2];
    logic [31:0] mm [2][DSIZE];
    logic [3:0]  kn [2][DSIZE];

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic bit req_is_err(input bit rd, input bit wr, input logic [31:0] a);
        bit e;
        e = (rd && wr) || ((a >> 2) >= DSIZE);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic model_step(input int d);
        int w;
        if (s_rst) begin
            pend[d]     = 1'b0;
            rd_val[d]   = '0;
            rd_known[d] = 1'b1;
        end else if (pend[d] && cyc == rdy_cyc[d] + 1) begin
            if (!req_is_err(m_rd[d], m_wr[d], m_addr[d])) begin
                w = int'(m_addr[d] >> 2);
                if (m_wr[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_be[d][b]) begin
                            mm[d][w][8*b +: 8] = m_data[d][8*b +: 8];
                            kn[d][w][b]        = 1'b1;
                        end
                    end
                end else begin
                    rd_val[d]   = mm[d][w];
                    rd_known[d] = (kn[d][w] == 4'hF);
                end
            end
            pend[d] = 1'b0;
        end else if (!pend[d] && (s_rd[d] || s_wr[d])) begin
            pend[d]    = 1'b1;
            m_rd[d]    = s_rd[d];
            m_wr[d]    = s_wr[d];
            m_addr[d]  = s_addr[d];
            m_data[d]  = s_data[d];
            m_be[d]    = s_be[d];
            rdy_cyc[d] = cyc + wait_of(d);
        end
    endtask

    task automatic compare(input int d);
        bit rdy_e;
        bit err_e;
        int w;
        rdy_e = pend[d] && (cyc == rdy_cyc[d]);
        err_e = rdy_e && req_is_err(m_rd[d], m_wr[d], m_addr[d]);
        check($sformatf("busy%0d", d),  32'(o_busy[d]),  32'(pend[d]));
        check($sformatf("ready%0d", d), 32'(o_ready[d]), 32'(rdy_e));
        check($sformatf("err%0d", d),   32'(o_err[d]),   32'(err_e));
        if (rdy_e && m_rd[d] && !m_wr[d] && !err_e) begin
            w = int'(m_addr[d] >> 2);
            if (kn[d][w] == 4'hF) check($sformatf("rdata%0d", d), o_dr[d], mm[d][w]);
        end else if (rd_known[d]) begin
            check($sformatf("hold%0d", d), o_dr[d], rd_val[d]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            rd_known[d] = 1'b0;
            for (int i = 0; i < DSIZE; i++) kn[d][i] = 4'h0;
        end
        forever begin
            @(negedge CLK);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                model_step(d);
                if (chk_en) compare(d);
            end
        end
    end

    // Called at posedge+1; holds the request until ready, returns at posedge+1.
    task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] be, input bit scramble,
                        output bit e, output logic [31:0] q, output int lat);
        bit got;
        got = 1'b0;
        e = 1'b0;
        q = '0;
        lat = 0;
        drv_rd[d] = rd; drv_wr[d] = wr; drv_addr[d] = a; drv_data[d] = data; drv_be[d] = be;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge CLK);
            if (o_ready[d]) begin
                got = 1'b1;
                e   = o_err[d];
                q   = o_dr[d];
            end else begin
                lat++;
                if (scramble && n >= 1) begin
                    drv_addr[d] = $urandom;
                    drv_data[d] = $urandom;
                    drv_be[d]   = 4'($urandom);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout dut%0d actual=no_ready required=ready_within_40", d);
        end
        @(posedge CLK); #1;
        drv_rd[d] = 1'b0;
        drv_wr[d] = 1'b0;
    endtask

    task automatic run_random(input int d, input int n);
        bit          e;
        logic [31:0] q;
        int          lat;
        int          k;
        int          sel;
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 255) << 2))
                                            : 32'($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            xfer(d, sel <= 4, sel == 0 || sel >= 5, a, $urandom, 4'($urandom), 1'b1, e, q, lat);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        bit          e;
        logic [31:0] q;
        int          lat;
        logic [7:0]  pat_r;
        logic [7:0]  pat_b;
        for (int d = 0; d < 2; d++) begin
            drv_rd[d] = 1'b0; drv_wr[d] = 1'b0;
            drv_addr[d] = '0; drv_data[d] = '0; drv_be[d] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        check("rst_ready", 32'(o_ready[0]), 32'd0);
        check("rst_err",   32'(o_err[0]),   32'd0);
        check("rst_busy",  32'(o_busy[0]),  32'd0);
        check("rst_ddata", o_dr[0], 32'h0);
        RESET = 1'b0;

        // WAIT_CYCLES=1 responder: directed scenarios.
        xfer(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, e, q, lat);
        check("wr10_latency", 32'(lat), 32'd2);
        check("wr10_err", 32'(e), 32'd0);
        xfer(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, e, q, lat);
        check("rd10_err", 32'(e), 32'd0);
        check("rd10_data", q, 32'hDEADBEEF);

        xfer(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 0, e, q, lat);
        xfer(0, 0, 1, 32'h20, 32'h0000AA00, 4'b0010, 0, e, q, lat);
        xfer(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, e, q, lat);
        check("be_merge_data", q, 32'h1122AA44);

        xfer(0, 0, 1, 32'h04, 32'hCAFEF00D, 4'hF, 0, e, q, lat);
        xfer(0, 1, 1, 32'h04, 32'h0, 4'hF, 0, e, q, lat);
        check("both_err", 32'(e), 32'd1);
        xfer(0, 1, 0, 32'h04, 32'h0, 4'h0, 0, e, q, lat);
        check("both_nowrite", q, 32'hCAFEF00D);

        xfer(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, e, q, lat);
        check("oor_err", 32'(e), 32'd1);
        check("oor_hold", q, 32'hCAFEF00D);

        xfer(0, 1, 0, 32'h22, 32'h0, 4'h0, 0, e, q, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("misalign_err", 32'(e), 32'd1);
        check("misalign_hold", q, 32'hCAFEF00D);
`else
        check("misalign_err", 32'(e), 32'd0);
        check("misalign_data", q, 32'h1122AA44);
`endif

        xfer(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, e, q, lat);
        check("be0_err", 32'(e), 32'd0);
        xfer(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, e, q, lat);
        check("be0_nochange", q, 32'h1122AA44);

        // Reset during WAIT abandons the write.
        xfer(0, 0, 1, 32'h30, 32'h12345678, 4'hF, 0, e, q, lat);
        drv_wr[0] = 1'b1; drv_addr[0] = 32'h30; drv_data[0] = 32'h55555555; drv_be[0] = 4'hF;
        @(posedge CLK); #1;
        check("rstmid_busy_wait", 32'(o_busy[0]), 32'd1);
        RESET = 1'b1;
        drv_wr[0] = 1'b0;
        @(negedge CLK);
        check("rstmid_no_ready", 32'(o_ready[0]), 32'd0);
        @(posedge CLK); #1;
        check("rstmid_busy", 32'(o_busy[0]), 32'd0);
        check("rstmid_ready", 32'(o_ready[0]), 32'd0);
        check("rstmid_ddata", o_dr[0], 32'h0);
        RESET = 1'b0;
        xfer(0, 1, 0, 32'h30, 32'h0, 4'h0, 0, e, q, lat);
        check("rstmid_old_data", q, 32'h12345678);

        run_random(0, 150);

        // WAIT_CYCLES=0 responder.
        xfer(1, 0, 1, 32'h10, 32'hA5A55A5A, 4'hF, 0, e, q, lat);
        check("w0_latency", 32'(lat), 32'd1);
        check("w0_err", 32'(e), 32'd0);
        drv_rd[1] = 1'b1; drv_addr[1] = 32'h10;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            pat_r[i] = o_ready[1];
            pat_b[i] = o_busy[1];
        end
        @(posedge CLK); #1;
        drv_rd[1] = 1'b0;
        check("held_ready_pattern", 32'(pat_r), 32'hAA);
        check("held_busy_pattern",  32'(pat_b), 32'hAA);
        xfer(1, 1, 0, 32'h10, 32'h0, 4'h0, 0, e, q, lat);
        check("w0_read", q, 32'hA5A55A5A);

        run_random(1, 150);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter data_size, default 1024, meaning storage depth in 32-bit words.
REQ-002 SHALL have parameter address_size, default 32, meaning width of daddr, ddata_w and ddata_r.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, meaning extra cycles between request acceptance and response (range 0-15).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MemRead  input  1  read request, held high until ready.
REQ-007 SHALL have port MemWrite  input  1  write request, held high until ready.
REQ-008 SHALL have port daddr  input  address_size  byte address; word index = daddr[$clog2(data_size)+1:2].
REQ-009 SHALL have port ddata_w  input  address_size  write data.
REQ-010 SHALL have port be  input  4  byte enables for writes; be[i] gates ddata_w[8i+7:8i].
REQ-011 SHALL have port ddata_r  output  address_size  read data, valid when ready=1.
REQ-012 SHALL have port ready  output  1  one-cycle pulse completing current request.
REQ-013 SHALL have port err  output  1  qualifies ready; 1 = request failed, no access performed.
REQ-014 SHALL have port busy  output  1  high from acceptance until the cycle of ready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, MemRead|MemWrite high SHALL latch daddr, ddata_w, be, request type; go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-017 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0 go to RESP.
REQ-018 In RESP, ready SHALL be 1 for exactly one cycle; next state IDLE; total latency acceptance-to-ready = WAIT_CYCLES+1 cycles.
REQ-019 Reads SHALL update ddata_r with the addressed word in the RESP cycle; ddata_r SHALL hold that value until the next successful read.
REQ-020 Writes SHALL commit the enabled bytes at the edge ending RESP; a read issued afterwards returns the new data.
REQ-021 MemRead and MemWrite both high at acceptance SHALL produce ready=1, err=1, no access.
REQ-022 Word index >= data_size SHALL produce err=1; writes dropped, ddata_r unchanged.
REQ-023 A write with be=4'b0000 SHALL complete with err=0 and no storage change.
REQ-024 Requests arriving while not in IDLE SHALL be ignored; the cycle after ready the block is in IDLE and may accept a held or new request.
REQ-025 Latched request fields SHALL be used for the access; input changes after acceptance SHALL have no effect.

Reset
REQ-026 RESET=1 at a rising edge SHALL force IDLE, counter 0, ready=0, err=0, busy=0, ddata_r=0.
REQ-027 Reset mid-operation SHALL abandon the request with no ready pulse and no write commit.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN defined: daddr[1:0]!=0 SHALL produce err=1 and no access.
REQ-030 Macro DMEM_MISALIGN_CHECK_EN undefined: daddr[1:0] SHALL be ignored and the access performed on the word index.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum, WAIT_CYCLES maximum, and the request record typedef (type, addr, data, be).
REQ-032 Storage SHALL be a sub-module dmem_array: synchronous byte-enabled write, combinational read, data_size x 32.

Verification
REQ-033 Reset then MemWrite daddr=0x10 ddata_w=0xDEADBEEF be=4'hF, WAIT_CYCLES=1 -> ready at cycle 2, err=0; MemRead 0x10 -> ddata_r=0xDEADBEEF.
REQ-034 Write 0x11223344 to 0x20, then be=4'b0010 data 0x0000AA00 -> read 0x20 returns 0x1122AA44.
REQ-035 MemRead and MemWrite both high at 0x04 -> ready=1, err=1, word 0x04 unchanged.
REQ-036 MemRead daddr=0x1000 (index 1024) -> err=1, ddata_r keeps previous value; daddr=0x22 -> err=1 with macro, read of word 0x20 without.
REQ-037 RESET asserted in WAIT of write 0x55555555 to 0x30 -> no ready pulse, busy=0 next cycle, read 0x30 returns old value.
REQ-038 WAIT_CYCLES=0 back-to-back held MemRead -> ready every second cycle, busy low only in IDLE cycles.
